// File: rtl/ysyx_25030085_mc_core.sv
// Multi-cycle RV32I/E subset core: FETCH -> WAIT -> EXEC per instruction.
// Supports addi/add/sub/lui/auipc/jal/jalr/ebreak; anything else halts as illegal.
module ysyx_25030085_mc_core #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          NR_REGS  = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req_valid,
   input  logic        ifu_req_ready,
   output logic [31:0] ifu_req_addr,
   input  logic        ifu_rsp_valid,
   input  logic [31:0] ifu_rsp_inst,
   output logic [31:0] pc_out,
   output logic        commit_valid,
   output logic [31:0] commit_pc,
   output logic [4:0]  commit_rd,
   output logic [31:0] commit_wdata,
   output logic        halt,
   output logic        illegal
);

   localparam int AW = $clog2(NR_REGS);
   localparam logic [5:0] NR = 6'(NR_REGS);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT
   } state_t;

   state_t      r_state, w_next;
   logic [31:0] r_pc, r_ir;
   logic [31:0] r_gpr [NR_REGS];
   logic        r_illegal;

   logic [6:0]  w_op, w_f7;
   logic [4:0]  w_rd, w_rs1, w_rs2;
   logic [2:0]  w_f3;
   logic [31:0] w_imm_i, w_imm_u, w_imm_j;
   logic        w_addi, w_add, w_sub, w_lui, w_auipc;
   logic        w_jal, w_jalr, w_ebreak;
   logic        w_use_rs1, w_use_rs2, w_badreg, w_legal, w_wen;
   logic [31:0] w_a, w_b, w_res, w_npc;

   assign w_op  = r_ir[6:0];
   assign w_rd  = r_ir[11:7];
   assign w_f3  = r_ir[14:12];
   assign w_rs1 = r_ir[19:15];
   assign w_rs2 = r_ir[24:20];
   assign w_f7  = r_ir[31:25];

   assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
   assign w_imm_u = {r_ir[31:12], 12'b0};
   assign w_imm_j = {{12{r_ir[31]}}, r_ir[19:12],
                     r_ir[20], r_ir[30:21], 1'b0};

   assign w_addi   = (w_op == 7'h13) && (w_f3 == 3'd0);
   assign w_add    = (w_op == 7'h33) && (w_f3 == 3'd0)
                     && (w_f7 == 7'h00);
   assign w_sub    = (w_op == 7'h33) && (w_f3 == 3'd0)
                     && (w_f7 == 7'h20);
   assign w_lui    = (w_op == 7'h37);
   assign w_auipc  = (w_op == 7'h17);
   assign w_jal    = (w_op == 7'h6f);
   assign w_jalr   = (w_op == 7'h67) && (w_f3 == 3'd0);
   assign w_ebreak = (r_ir == 32'h0010_0073);

   // Register-index range is only checked on fields the instruction uses
   assign w_use_rs1 = w_addi | w_add | w_sub | w_jalr;
   assign w_use_rs2 = w_add | w_sub;
   assign w_badreg  = (!w_ebreak && ({1'b0, w_rd} >= NR))
                    | (w_use_rs1 && ({1'b0, w_rs1} >= NR))
                    | (w_use_rs2 && ({1'b0, w_rs2} >= NR));
   assign w_legal   = (w_addi | w_add | w_sub | w_lui | w_auipc
                     | w_jal | w_jalr | w_ebreak) && !w_badreg;
   assign w_wen     = w_legal && !w_ebreak && (w_rd != 5'd0);

   // x0 is never written, so its slot always reads zero
   assign w_a = r_gpr[w_rs1[AW-1:0]];
   assign w_b = r_gpr[w_rs2[AW-1:0]];

   always_comb begin
      w_res = '0;
      w_npc = r_pc + 32'd4;
      unique case (1'b1)
         w_addi:  w_res = w_a + w_imm_i;
         w_add:   w_res = w_a + w_b;
         w_sub:   w_res = w_a - w_b;
         w_lui:   w_res = w_imm_u;
         w_auipc: w_res = r_pc + w_imm_u;
         w_jal: begin
            w_res = r_pc + 32'd4;
            w_npc = r_pc + w_imm_j;
         end
         w_jalr: begin
            w_res = r_pc + 32'd4;
            w_npc = (w_a + w_imm_i) & ~32'd1;
         end
         default: w_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  w_next = S_FETCH;
         S_FETCH: if (ifu_req_ready) w_next = S_WAIT;
         S_WAIT:  if (ifu_rsp_valid) w_next = S_EXEC;
         S_EXEC:  w_next = (!w_legal || w_ebreak) ? S_HALT
                                                   : S_FETCH;
         S_HALT:  w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      ifu_req_valid = (r_state == S_FETCH);
      commit_valid  = (r_state == S_EXEC) && w_legal;
      commit_pc     = commit_valid ? r_pc : '0;
      commit_rd     = (commit_valid && w_wen) ? w_rd : '0;
      commit_wdata  = (commit_valid && w_wen) ? w_res : '0;
      halt          = (r_state == S_HALT);
      illegal       = r_illegal;
   end

   assign ifu_req_addr = r_pc;
   assign pc_out       = r_pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc      <= RESET_PC;
         r_ir      <= '0;
         r_illegal <= 1'b0;
         for (int i = 0; i < NR_REGS; i++) r_gpr[i] <= '0;
      end else begin
         if (r_state == S_WAIT && ifu_rsp_valid)
            r_ir <= ifu_rsp_inst;
         if (r_state == S_EXEC) begin
            if (!w_legal) begin
               r_illegal <= 1'b1;
            end else begin
               // ebreak leaves PC on itself so the halt point is visible
               if (!w_ebreak) r_pc <= w_npc;
               if (w_wen) r_gpr[w_rd[AW-1:0]] <= w_res;
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_25030085_mc_core.sv
// Directed bench: RV32E instance (a_*) and RV32I instance (b_*)
// share the fetch bus; vector table plus reset/illegal sequences.
module tb_ysyx_25030085_mc_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ready = 1'b0;
   logic        rspv = 1'b0;
   logic [31:0] inst = '0;

   logic        a_rv, a_cv, a_halt, a_ill;
   logic [31:0] a_addr, a_pc, a_cpc, a_cwd;
   logic [4:0]  a_crd;
   logic        b_rv, b_cv, b_halt, b_ill;
   logic [31:0] b_addr, b_pc, b_cpc, b_cwd;
   logic [4:0]  b_crd;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ysyx_25030085_mc_core #(.NR_REGS(16)) u_a (
      .clk(clk), .rst(rst),
      .ifu_req_valid(a_rv), .ifu_req_ready(ready),
      .ifu_req_addr(a_addr), .ifu_rsp_valid(rspv),
      .ifu_rsp_inst(inst), .pc_out(a_pc),
      .commit_valid(a_cv), .commit_pc(a_cpc),
      .commit_rd(a_crd), .commit_wdata(a_cwd),
      .halt(a_halt), .illegal(a_ill)
   );

   ysyx_25030085_mc_core #(.NR_REGS(32)) u_b (
      .clk(clk), .rst(rst),
      .ifu_req_valid(b_rv), .ifu_req_ready(ready),
      .ifu_req_addr(b_addr), .ifu_rsp_valid(rspv),
      .ifu_rsp_inst(inst), .pc_out(b_pc),
      .commit_valid(b_cv), .commit_pc(b_cpc),
      .commit_rd(b_crd), .commit_wdata(b_cwd),
      .halt(b_halt), .illegal(b_ill)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic        chk_wd;
      int          rdly;
      int          sdly;
   } vec_t;

   vec_t v[12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_fetch();
      int n = 0;
      while (a_rv !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("fetch_timeout", 32'(a_rv), 32'd1);
   endtask

   // Entered at a negedge in FETCH; returns at the negedge of EXEC.
   task automatic xfer(input logic [31:0] ins, input int rd_dly,
                       input int rs_dly, input logic [31:0] pc);
      ready = 1'b0;
      repeat (rd_dly) begin
         chk("hold_addr", a_addr, pc);
         chk("hold_valid", 32'(a_rv), 32'd1);
         chk("hold_nocommit", 32'(a_cv), 32'd0);
         step();
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("wait_valid", 32'(a_rv), 32'd0);
      repeat (rs_dly) begin
         chk("wait_nocommit", 32'(a_cv), 32'd0);
         step();
      end
      rspv = 1'b1;
      inst = ins;
      step();
      rspv = 1'b0;
      inst = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b0;
      ready = 1'b0;
      rspv  = 1'b0;
      #1;
      chk("rst_pc", a_pc, 32'h8000_0000);
      chk("rst_rv", 32'(a_rv), 32'd0);
      chk("rst_halt", 32'(a_halt), 32'd0);
      chk("rst_ill", 32'(a_ill), 32'd0);
      chk("rst_cv", 32'(a_cv), 32'd0);
      chk("rst_cpc", a_cpc, 32'd0);
      chk("rst_crd", 32'(a_crd), 32'd0);
      chk("rst_cwd", a_cwd, 32'd0);
      step();
      rst = 1'b1;
      #1;
      chk("idle_rv", 32'(a_rv), 32'd0);
      step();
      chk("first_req", 32'(a_rv), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded", $time);
      $fatal(1);
   end

   initial begin
      int t0;
      v[0]  = '{32'h8000_0000, 32'h0050_0093, 5'd1,
                32'h0000_0005, 1'b1, 0, 0};
      v[1]  = '{32'h8000_0004, 32'h0010_8133, 5'd2,
                32'h0000_000A, 1'b1, 0, 0};
      v[2]  = '{32'h8000_0008, 32'h4020_81B3, 5'd3,
                32'hFFFF_FFFB, 1'b1, 4, 3};
      v[3]  = '{32'h8000_000C, 32'h1234_5237, 5'd4,
                32'h1234_5000, 1'b1, 0, 0};
      v[4]  = '{32'h8000_0010, 32'h0000_1297, 5'd5,
                32'h8000_1010, 1'b1, 0, 0};
      v[5]  = '{32'h8000_0014, 32'hFFF1_8313, 5'd6,
                32'hFFFF_FFFA, 1'b1, 0, 0};
      v[6]  = '{32'h8000_0018, 32'h0070_8013, 5'd0,
                32'h0000_0000, 1'b0, 0, 0};
      v[7]  = '{32'h8000_001C, 32'h0080_00EF, 5'd1,
                32'h8000_0020, 1'b1, 0, 0};
      v[8]  = '{32'h8000_0024, 32'h0000_0497, 5'd9,
                32'h8000_0024, 1'b1, 0, 0};
      v[9]  = '{32'h8000_0028, 32'h0114_8467, 5'd8,
                32'h8000_002C, 1'b1, 1, 1};
      v[10] = '{32'h8000_0034, 32'h0044_0533, 5'd10,
                32'h9234_502C, 1'b1, 0, 0};
      v[11] = '{32'h8000_0038, 32'h0010_0073, 5'd0,
                32'h0000_0000, 1'b0, 0, 0};

      do_reset();
      t0 = 0;
      for (int i = 0; i < 12; i++) begin
         wait_fetch();
         chk($sformatf("v%0d_addr", i), a_addr, v[i].pc);
         chk($sformatf("v%0d_pcout", i), a_pc, v[i].pc);
         xfer(v[i].ins, v[i].rdly, v[i].sdly, v[i].pc);
         chk($sformatf("v%0d_cv", i), 32'(a_cv), 32'd1);
         chk($sformatf("v%0d_cpc", i), a_cpc, v[i].pc);
         chk($sformatf("v%0d_crd", i), 32'(a_crd),
             32'(v[i].rd));
         if (v[i].chk_wd)
            chk($sformatf("v%0d_cwd", i), a_cwd, v[i].wd);
         chk($sformatf("v%0d_b_crd", i), 32'(b_crd),
             32'(v[i].rd));
         if (i == 1) chk("commit_gap", 32'(cyc - t0), 32'd3);
         t0 = cyc;
      end
      step();
      chk("ebreak_halt", 32'(a_halt), 32'd1);
      chk("ebreak_ill", 32'(a_ill), 32'd0);
      chk("ebreak_pc", a_pc, 32'h8000_0038);
      repeat (4) begin
         chk("halt_rv", 32'(a_rv), 32'd0);
         chk("halt_cv", 32'(a_cv), 32'd0);
         step();
      end

      // x20 is out of range only for the 16-register core
      do_reset();
      wait_fetch();
      xfer(32'h0010_0A13, 0, 0, 32'h8000_0000);
      chk("ill_a_cv", 32'(a_cv), 32'd0);
      chk("ill_b_cv", 32'(b_cv), 32'd1);
      chk("ill_b_crd", 32'(b_crd), 32'd20);
      chk("ill_b_cwd", b_cwd, 32'd1);
      step();
      chk("ill_halt", 32'(a_halt), 32'd1);
      chk("ill_flag", 32'(a_ill), 32'd1);
      chk("ill_pc", a_pc, 32'h8000_0000);
      chk("ill_b_rv", 32'(b_rv), 32'd1);
      chk("ill_b_halt", 32'(b_halt), 32'd0);
      repeat (4) begin
         chk("ill_rv", 32'(a_rv), 32'd0);
         chk("ill_cv", 32'(a_cv), 32'd0);
         step();
      end

      // Reset mid-WAIT with a response that arrives too late
      do_reset();
      wait_fetch();
      ready = 1'b1;
      step();
      ready = 1'b0;
      rst  = 1'b0;
      rspv = 1'b1;
      inst = 32'h0050_0093;
      #1;
      chk("mid_pc", a_pc, 32'h8000_0000);
      chk("mid_rv", 32'(a_rv), 32'd0);
      chk("mid_halt", 32'(a_halt), 32'd0);
      step();
      rst = 1'b1;
      #1;
      chk("mid_idle_rv", 32'(a_rv), 32'd0);
      step();
      chk("mid_fetch_rv", 32'(a_rv), 32'd1);
      chk("mid_fetch_addr", a_addr, 32'h8000_0000);
      step();
      rspv = 1'b0;
      inst = '0;
      chk("stale_cv", 32'(a_cv), 32'd0);
      chk("stale_rv", 32'(a_rv), 32'd1);
      wait_fetch();
      xfer(32'h0030_0113, 0, 0, 32'h8000_0000);
      chk("post_cv", 32'(a_cv), 32'd1);
      chk("post_cpc", a_cpc, 32'h8000_0000);
      chk("post_crd", 32'(a_crd), 32'd2);
      chk("post_cwd", a_cwd, 32'd3);

      wait_fetch();
      chk("jal_addr", a_addr, 32'h8000_0004);
      xfer(32'h0080_00EF, 0, 0, 32'h8000_0004);
      chk("jal_crd", 32'(a_crd), 32'd1);
      chk("jal_cwd", a_cwd, 32'h8000_0008);
      wait_fetch();
      chk("jal_target", a_addr, 32'h8000_000C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
